tape_recorder: RTL and testbench

Decodes the Oric cassette output (`K7_TAPEOUT`, fast 2400-baud format) back into bytes and writes them sequentially into a byte buffer, from which the HPS saves a TAP file. It is the record path paired with the cassette playback path, sitting in the top level between the `oricatmos` core's tape output and a dual-port tape-save BRAM.

---
 rtl/tape_pkg.sv | 24 ++
 rtl/tape_period_meter.sv | 80 ++++++++
 rtl/tape_recorder.sv | 136 +++++++++++++
 tb/tb_tape_recorder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tape_pkg.sv
// Shared types and helpers for the cassette record path.
package tape_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HUNT,
        DATA,
        PARITY,
        STOP
    } rec_state_t;

    typedef enum logic [1:0] {
        GLITCH,
        ONE,
        ZERO,
        TIMEOUT
    } bit_class_t;

    // Elaboration-time microsecond-to-tick conversion, truncating.
    function automatic int us_to_ticks(input longint clk_hz, input longint us);
        return int'((clk_hz * us) / 64'd1_000_000);
    endfunction

endpackage

// File: rtl/tape_period_meter.sv
// Synchronizes K7_TAPEOUT, measures rising-edge to rising-edge periods and
// classifies each period as a 1, a 0, a glitch or a gap.
module tape_period_meter
    import tape_pkg::*;
#(
    parameter int CLK_HZ = 24_000_000,
    parameter int MIN_US = 100,
    parameter int MID_US = 312,
    parameter int MAX_US = 700
) (
    input  logic clk_sys,
    input  logic RESET,
    input  logic tape_out,
    output logic bit_valid,
    output logic bit_val,
    output logic timeout
);

    localparam int MIN_T = us_to_ticks(CLK_HZ, MIN_US);
    localparam int MID_T = us_to_ticks(CLK_HZ, MID_US);
    localparam int MAX_T = us_to_ticks(CLK_HZ, MAX_US);
    localparam int CW    = $clog2(MAX_T) + 1;

    localparam logic [CW-1:0] MIN_C = CW'(MIN_T);
    localparam logic [CW-1:0] MID_C = CW'(MID_T);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_T);

    logic          sync1;
    logic          sync2;
    logic          sync_d;
    logic          rise;
    logic          rise_accept;
    logic [CW-1:0] cnt;
    bit_class_t    cls;

    assign rise = sync2 & ~sync_d;

    // Classify the period that ends at the current counter value.
    always_comb begin
        cls = GLITCH;
        if (cnt < MIN_C)
            cls = GLITCH;
        else if (cnt < MID_C)
            cls = ONE;
        else if (cnt < MAX_C)
            cls = ZERO;
        else
            cls = TIMEOUT;
    end

    // A rise after a gap is not a bit but still restarts the measurement.
    assign rise_accept = rise && (cls != GLITCH);
    assign bit_valid   = rise && ((cls == ONE) || (cls == ZERO));
    assign bit_val     = (cls == ONE);
    assign timeout     = !rise_accept && (cnt == MAX_C - CW'(1));

    // Two-flop synchronizer followed by the edge-detect register.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            sync1  <= tape_out;
            sync2  <= sync1;
            sync_d <= sync2;
        end
    end

    // Period counter; loads 1 so the value seen at the next rise equals the period.
    always_ff @(posedge clk_sys) begin
        if (RESET)
            cnt <= '0;
        else if (rise_accept)
            cnt <= CW'(1);
        else if (cnt != MAX_C)
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/tape_recorder.sv
// Record path: turns the decoded tape bit stream into bytes and writes them
// sequentially into the tape-save buffer.
//
// state  | meaning
// IDLE   | not recording (arm or motor low, after clear or reset)
// HUNT   | waiting for a start bit; leader and stop 1s are ignored
// DATA   | shifting in 8 data bits, LSB first
// PARITY | waiting for the odd-parity bit
// STOP   | waiting for the stop bit; 1 commits, 0 is a framing error
module tape_recorder
    import tape_pkg::*;
#(
    parameter int CLK_HZ = 24_000_000,
    parameter int ADDR_W = 16,
    parameter int MIN_US = 100,
    parameter int MID_US = 312,
    parameter int MAX_US = 700
) (
    input  logic              clk_sys,
    input  logic              RESET,
    input  logic              tape_out,
    input  logic              motor,
    input  logic              arm,
    input  logic              clear,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [ADDR_W:0]   rec_len,
    output logic              overflow,
    output logic [7:0]        parity_errs,
    output logic [7:0]        frame_errs,
    output logic              active
);

    logic       bit_valid;
    logic       bit_val;
    logic       timeout;
    rec_state_t state;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;

    tape_period_meter #(
        .CLK_HZ (CLK_HZ),
        .MIN_US (MIN_US),
        .MID_US (MID_US),
        .MAX_US (MAX_US)
    ) u_meter (
        .clk_sys   (clk_sys),
        .RESET     (RESET),
        .tape_out  (tape_out),
        .bit_valid (bit_valid),
        .bit_val   (bit_val),
        .timeout   (timeout)
    );

    assign active = (state != IDLE);

    // Framer FSM with buffer address generation and error counters.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            rec_len     <= '0;
            overflow    <= 1'b0;
            parity_errs <= '0;
            frame_errs  <= '0;
        end else begin
            wr_en <= 1'b0;
            if (clear) begin
                rec_len     <= '0;
                overflow    <= 1'b0;
                parity_errs <= '0;
                frame_errs  <= '0;
                state       <= IDLE;
            end else if (!(arm && motor)) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: state <= HUNT;
                    HUNT: begin
                        if (bit_valid && !bit_val) begin
                            shreg   <= '0;
                            bit_cnt <= '0;
                            state   <= DATA;
                        end
                    end
                    DATA: begin
                        if (timeout) begin
                            state <= HUNT;
                        end else if (bit_valid) begin
                            shreg   <= {bit_val, shreg[7:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7)
                                state <= PARITY;
                        end
                    end
                    PARITY: begin
                        if (timeout) begin
                            state <= HUNT;
                        end else if (bit_valid) begin
                            // Odd parity: data plus parity bit must hold an odd count of ones.
                            if (!(^{shreg, bit_val}) && (parity_errs != 8'hFF))
                                parity_errs <= parity_errs + 8'd1;
                            state <= STOP;
                        end
                    end
                    STOP: begin
                        if (timeout) begin
                            state <= HUNT;
                        end else if (bit_valid) begin
                            if (bit_val) begin
                                if (!rec_len[ADDR_W]) begin
                                    wr_en   <= 1'b1;
                                    wr_addr <= rec_len[ADDR_W-1:0];
                                    wr_data <= shreg;
                                    rec_len <= rec_len + (ADDR_W+1)'(1);
                                end else begin
                                    overflow <= 1'b1;
                                end
                            end else if (frame_errs != 8'hFF) begin
                                frame_errs <= frame_errs + 8'd1;
                            end
                            state <= HUNT;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tape_recorder.sv
// Directed bench for tape_recorder at 1 tick per clock (CLK_HZ = 1 MHz).
module tb_tape_recorder;

    logic        clk_sys = 1'b0;
    logic        RESET   = 1'b1;
    logic        tape_out = 1'b0;
    logic        motor   = 1'b1;
    logic        arm     = 1'b1;
    logic        clear   = 1'b0;
    logic        arm_s   = 1'b0;
    logic        clear_s = 1'b0;

    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic [16:0] rec_len;
    logic        overflow;
    logic [7:0]  parity_errs;
    logic [7:0]  frame_errs;
    logic        active;

    logic        wr_en_s;
    logic [1:0]  wr_addr_s;
    logic [7:0]  wr_data_s;
    logic [2:0]  rec_len_s;
    logic        overflow_s;
    logic [7:0]  parity_errs_s;
    logic [7:0]  frame_errs_s;
    logic        active_s;

    int n_cmp = 0;
    int n_err = 0;

    int         wr_cnt = 0;
    logic [15:0] last_addr = '0;
    logic [7:0]  last_data = '0;
    logic [1:0]  log_addr_s[$];
    logic [7:0]  log_data_s[$];

    always #5 clk_sys = ~clk_sys;

    tape_recorder #(.CLK_HZ(1_000_000), .ADDR_W(16)) dut (
        .clk_sys(clk_sys), .RESET(RESET), .tape_out(tape_out), .motor(motor),
        .arm(arm), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rec_len(rec_len), .overflow(overflow),
        .parity_errs(parity_errs), .frame_errs(frame_errs), .active(active)
    );

    tape_recorder #(.CLK_HZ(1_000_000), .ADDR_W(2)) dut_s (
        .clk_sys(clk_sys), .RESET(RESET), .tape_out(tape_out), .motor(motor),
        .arm(arm_s), .clear(clear_s), .wr_en(wr_en_s), .wr_addr(wr_addr_s),
        .wr_data(wr_data_s), .rec_len(rec_len_s), .overflow(overflow_s),
        .parity_errs(parity_errs_s), .frame_errs(frame_errs_s), .active(active_s)
    );

    // Capture write strobes away from the active edge.
    always @(negedge clk_sys) begin
        if (wr_en === 1'b1) begin
            wr_cnt    = wr_cnt + 1;
            last_addr = wr_addr;
            last_data = wr_data;
        end
        if (wr_en_s === 1'b1) begin
            log_addr_s.push_back(wr_addr_s);
            log_data_s.push_back(wr_data_s);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic send_bit(input logic b, input logic g);
        int per;
        per = b ? 208 : 416;
        tape_out = 1'b1;
        if (g) begin
            wait_cyc(20);
            tape_out = 1'b0;
            wait_cyc(30);
            tape_out = 1'b1;
            wait_cyc(10);
            tape_out = 1'b0;
            wait_cyc(per - 60);
        end else begin
            wait_cyc(per / 2);
            tape_out = 1'b0;
            wait_cyc(per - per / 2);
        end
    endtask

    task automatic send_gap(input int n);
        tape_out = 1'b0;
        wait_cyc(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stop_b,
                              input logic g, input int nlead);
        send_gap(720);
        for (int i = 0; i < nlead; i++) send_bit(1'b1, 1'b0);
        send_bit(1'b0, g);
        for (int i = 0; i < 8; i++) send_bit(d[i], g);
        send_bit((~^d) ^ pflip, g);
        send_bit(stop_b, g);
        send_bit(1'b1, 1'b0);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        wait_cyc(1);
        clear = 1'b0;
        wait_cyc(2);
    endtask

    task automatic test_reset();
        wait_cyc(3);
        n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
        n_cmp++; if (wr_addr !== 16'h0) begin n_err++; $display("FAIL reset_wr_addr: got %h expected 0", wr_addr); end
        n_cmp++; if (wr_data !== 8'h0) begin n_err++; $display("FAIL reset_wr_data: got %h expected 0", wr_data); end
        n_cmp++; if (rec_len !== 17'h0) begin n_err++; $display("FAIL reset_rec_len: got %0d expected 0", rec_len); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        n_cmp++; if (parity_errs !== 8'h0) begin n_err++; $display("FAIL reset_parity_errs: got %0d expected 0", parity_errs); end
        n_cmp++; if (frame_errs !== 8'h0) begin n_err++; $display("FAIL reset_frame_errs: got %0d expected 0", frame_errs); end
        n_cmp++; if (active !== 1'b0) begin n_err++; $display("FAIL reset_active: got %b expected 0", active); end
        RESET = 1'b0;
        wait_cyc(2);
        n_cmp++; if (active !== 1'b1) begin n_err++; $display("FAIL armed_active: got %b expected 1", active); end
        n_cmp++; if (active_s !== 1'b0) begin n_err++; $display("FAIL unarmed_active: got %b expected 0", active_s); end
    endtask

    task automatic test_basic_byte();
        int c0;
        c0 = wr_cnt;
        send_frame(8'h16, 1'b0, 1'b1, 1'b0, 20);
        n_cmp++; if (wr_cnt !== c0 + 1) begin n_err++; $display("FAIL basic_wr_count: got %0d expected %0d", wr_cnt - c0, 1); end
        n_cmp++; if (last_addr !== 16'h0) begin n_err++; $display("FAIL basic_wr_addr: got %h expected 0", last_addr); end
        n_cmp++; if (last_data !== 8'h16) begin n_err++; $display("FAIL basic_wr_data: got %h expected 16", last_data); end
        n_cmp++; if (rec_len !== 17'd1) begin n_err++; $display("FAIL basic_rec_len: got %0d expected 1", rec_len); end
        n_cmp++; if (parity_errs !== 8'd0) begin n_err++; $display("FAIL basic_parity_errs: got %0d expected 0", parity_errs); end
    endtask

    task automatic test_parity_error();
        int c0;
        pulse_clear();
        c0 = wr_cnt;
        send_frame(8'h16, 1'b1, 1'b1, 1'b0, 4);
        n_cmp++; if (wr_cnt !== c0 + 1) begin n_err++; $display("FAIL parity_wr_count: got %0d expected 1", wr_cnt - c0); end
        n_cmp++; if (last_data !== 8'h16) begin n_err++; $display("FAIL parity_wr_data: got %h expected 16", last_data); end
        n_cmp++; if (last_addr !== 16'h0) begin n_err++; $display("FAIL parity_wr_addr: got %h expected 0", last_addr); end
        n_cmp++; if (parity_errs !== 8'd1) begin n_err++; $display("FAIL parity_errs: got %0d expected 1", parity_errs); end
        n_cmp++; if (frame_errs !== 8'd0) begin n_err++; $display("FAIL parity_frame_errs: got %0d expected 0", frame_errs); end
    endtask

    task automatic test_frame_error();
        int c0;
        pulse_clear();
        n_cmp++; if (parity_errs !== 8'd0) begin n_err++; $display("FAIL clear_parity_errs: got %0d expected 0", parity_errs); end
        c0 = wr_cnt;
        send_frame(8'h16, 1'b0, 1'b0, 1'b0, 4);
        n_cmp++; if (wr_cnt !== c0) begin n_err++; $display("FAIL frame_no_write: got %0d writes expected 0", wr_cnt - c0); end
        n_cmp++; if (frame_errs !== 8'd1) begin n_err++; $display("FAIL frame_errs: got %0d expected 1", frame_errs); end
        send_frame(8'h24, 1'b0, 1'b1, 1'b0, 4);
        n_cmp++; if (wr_cnt !== c0 + 1) begin n_err++; $display("FAIL frame_next_count: got %0d expected 1", wr_cnt - c0); end
        n_cmp++; if (last_addr !== 16'h0) begin n_err++; $display("FAIL frame_next_addr: got %h expected 0", last_addr); end
        n_cmp++; if (last_data !== 8'h24) begin n_err++; $display("FAIL frame_next_data: got %h expected 24", last_data); end
        n_cmp++; if (parity_errs !== 8'd0) begin n_err++; $display("FAIL frame_next_parity: got %0d expected 0", parity_errs); end
    endtask

    task automatic test_glitch_gap();
        int c0;
        logic [7:0] d;
        pulse_clear();
        c0 = wr_cnt;
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 4);
        n_cmp++; if (wr_cnt !== c0 + 1) begin n_err++; $display("FAIL glitch_wr_count: got %0d expected 1", wr_cnt - c0); end
        n_cmp++; if (last_data !== 8'hA5) begin n_err++; $display("FAIL glitch_wr_data: got %h expected a5", last_data); end
        n_cmp++; if (last_addr !== 16'h0) begin n_err++; $display("FAIL glitch_wr_addr: got %h expected 0", last_addr); end
        d = 8'h3C;
        send_gap(720);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i], 1'b0);
        send_gap(900);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        send_gap(720);
        n_cmp++; if (wr_cnt !== c0 + 1) begin n_err++; $display("FAIL gap_discard: got %0d writes expected 1", wr_cnt - c0); end
        n_cmp++; if (rec_len !== 17'd1) begin n_err++; $display("FAIL gap_rec_len: got %0d expected 1", rec_len); end
        n_cmp++; if (parity_errs !== 8'd0) begin n_err++; $display("FAIL gap_parity_errs: got %0d expected 0", parity_errs); end
        n_cmp++; if (frame_errs !== 8'd0) begin n_err++; $display("FAIL gap_frame_errs: got %0d expected 0", frame_errs); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_d;
        arm_s = 1'b1;
        for (int k = 1; k <= 6; k++) send_frame(8'(k * 17), 1'b0, 1'b1, 1'b0, 2);
        n_cmp++; if (log_data_s.size() !== 4) begin n_err++; $display("FAIL ovf_write_count: got %0d expected 4", log_data_s.size()); end
        for (int k = 0; k < 4 && k < log_data_s.size(); k++) begin
            exp_d = 8'((k + 1) * 17);
            n_cmp++; if (log_addr_s[k] !== 2'(k)) begin n_err++; $display("FAIL ovf_addr[%0d]: got %0d expected %0d", k, log_addr_s[k], k); end
            n_cmp++; if (log_data_s[k] !== exp_d) begin n_err++; $display("FAIL ovf_data[%0d]: got %h expected %h", k, log_data_s[k], exp_d); end
        end
        n_cmp++; if (rec_len_s !== 3'd4) begin n_err++; $display("FAIL ovf_rec_len: got %0d expected 4", rec_len_s); end
        n_cmp++; if (overflow_s !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b expected 1", overflow_s); end
        clear_s = 1'b1;
        wait_cyc(1);
        clear_s = 1'b0;
        wait_cyc(1);
        n_cmp++; if (rec_len_s !== 3'd0) begin n_err++; $display("FAIL ovf_clear_len: got %0d expected 0", rec_len_s); end
        n_cmp++; if (overflow_s !== 1'b0) begin n_err++; $display("FAIL ovf_clear_flag: got %b expected 0", overflow_s); end
        arm_s = 1'b0;
    endtask

    task automatic test_abort();
        int c0;
        int len0;
        logic [7:0] d;
        d = 8'h5A;
        c0 = wr_cnt;
        len0 = int'(rec_len);
        send_gap(720);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(d[i], 1'b0);
        motor = 1'b0;
        wait_cyc(1);
        n_cmp++; if (active !== 1'b0) begin n_err++; $display("FAIL motor_drop_active: got %b expected 0", active); end
        for (int i = 3; i < 8; i++) send_bit(d[i], 1'b0);
        send_bit(~^d, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        n_cmp++; if (wr_cnt !== c0) begin n_err++; $display("FAIL motor_drop_no_write: got %0d writes expected 0", wr_cnt - c0); end
        n_cmp++; if (int'(rec_len) !== len0) begin n_err++; $display("FAIL motor_drop_len_kept: got %0d expected %0d", rec_len, len0); end
        motor = 1'b1;
        send_gap(720);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(d[i], 1'b0);
        n_cmp++; if (active !== 1'b1) begin n_err++; $display("FAIL pre_reset_active: got %b expected 1", active); end
        RESET = 1'b1;
        wait_cyc(1);
        n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL rst_wr_en: got %b expected 0", wr_en); end
        n_cmp++; if (wr_addr !== 16'h0) begin n_err++; $display("FAIL rst_wr_addr: got %h expected 0", wr_addr); end
        n_cmp++; if (wr_data !== 8'h0) begin n_err++; $display("FAIL rst_wr_data: got %h expected 0", wr_data); end
        n_cmp++; if (rec_len !== 17'h0) begin n_err++; $display("FAIL rst_rec_len: got %0d expected 0", rec_len); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow: got %b expected 0", overflow); end
        n_cmp++; if (parity_errs !== 8'h0) begin n_err++; $display("FAIL rst_parity_errs: got %0d expected 0", parity_errs); end
        n_cmp++; if (frame_errs !== 8'h0) begin n_err++; $display("FAIL rst_frame_errs: got %0d expected 0", frame_errs); end
        n_cmp++; if (active !== 1'b0) begin n_err++; $display("FAIL rst_active: got %b expected 0", active); end
        RESET = 1'b0;
        send_gap(1000);
        n_cmp++; if (wr_cnt !== c0) begin n_err++; $display("FAIL rst_no_write: got %0d writes expected 0", wr_cnt - c0); end
    endtask

    initial begin
        test_reset();
        test_basic_byte();
        test_parity_error();
        test_frame_error();
        test_glitch_gap();
        test_overflow();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
